rplx_match_scheduler: RTL

Shares one pattern-matching VM engine between `NREQ` requesters. Each requester submits a match job (start program counter, start input position). The scheduler grants jobs round-robin, launches and supervises the engine, and enforces an optional per-job cycle budget by aborting runaway jobs. It returns each result (matched, end position, aborted flag) to the requester that owns the job. It sits between the host-side job queues and the VM core.

---
 rtl/rplx_match_scheduler_if.sv | 36 +++
 rtl/rplx_match_scheduler.sv | 89 ++++++++
 2 files changed

// File: rtl/rplx_match_scheduler_if.sv
// rplx_match_scheduler_if: requester, engine and response signals of the match scheduler
interface rplx_match_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int PC_W  = 16,
  parameter int POS_W = 16,
  parameter int CNT_W = 24
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*PC_W-1:0]  req_pc;
  logic [NREQ*POS_W-1:0] req_pos;
  logic                  eng_start;
  logic [PC_W-1:0]       eng_pc;
  logic [POS_W-1:0]      eng_pos;
  logic                  eng_halt;
  logic                  eng_done;
  logic                  eng_matched;
  logic [POS_W-1:0]      eng_end_pos;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic                  rsp_matched;
  logic                  rsp_aborted;
  logic [POS_W-1:0]      rsp_pos;
  logic [CNT_W-1:0]      last_cycles;
  logic                  busy;
  modport master (
    input  req_valid, req_pc, req_pos, eng_done, eng_matched, eng_end_pos, rsp_ready,
    output req_ready, eng_start, eng_pc, eng_pos, eng_halt,
           rsp_valid, rsp_matched, rsp_aborted, rsp_pos, last_cycles, busy
  );
  modport slave (
    output req_valid, req_pc, req_pos, eng_done, eng_matched, eng_end_pos, rsp_ready,
    input  req_ready, eng_start, eng_pc, eng_pos, eng_halt,
           rsp_valid, rsp_matched, rsp_aborted, rsp_pos, last_cycles, busy
  );
endinterface

// File: rtl/rplx_match_scheduler.sv
// rplx_match_scheduler: round-robin sharing of one match engine with a per-job cycle watchdog
module rplx_match_scheduler #(
  parameter int NREQ       = 4,
  parameter int PC_W       = 16,
  parameter int POS_W      = 16,
  parameter int CNT_W      = 24,
  parameter int MAX_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  rplx_match_scheduler_if.master bus
);
  localparam int PTR_W = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, START, RUN, ABORT, RESP} state_t;
  state_t state, state_n;
  logic [PTR_W-1:0] rr_ptr, owner, gnt;
  logic gnt_ok, accept, expire, rsp_hs;
  logic [CNT_W-1:0] cnt, cnt_inc;
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req_valid[PTR_W'((int'(rr_ptr) + i) % NREQ)]) begin
        gnt = PTR_W'((int'(rr_ptr) + i) % NREQ);
        gnt_ok = 1'b1;
      end
  end
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign accept  = state == IDLE && gnt_ok;
  assign expire  = MAX_CYCLES != 0 && cnt_inc == CNT_W'(MAX_CYCLES);
  assign rsp_hs  = state == RESP && bus.rsp_ready[owner];
  // req_ready is combinational, so it is gated by rst to stay low throughout reset
  assign bus.req_ready = accept && !rst ? NREQ'(1) << gnt : '0;
  assign bus.rsp_valid = state == RESP ? NREQ'(1) << owner : '0;
  assign bus.eng_start = state == START;
  assign bus.busy      = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? START : IDLE;
      START:   state_n = RUN;
      RUN:     state_n = bus.eng_done ? RESP : expire ? ABORT : RUN;
      ABORT:   state_n = bus.eng_done ? RESP : ABORT;
      RESP:    state_n = rsp_hs ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      bus.eng_pc <= '0;
      bus.eng_pos <= '0;
      bus.eng_halt <= 1'b0;
      bus.rsp_matched <= 1'b0;
      bus.rsp_aborted <= 1'b0;
      bus.rsp_pos <= '0;
      bus.last_cycles <= '0;
    end else begin
      bus.eng_halt <= state == RUN && !bus.eng_done && expire;
      if (accept) begin
        owner <= gnt;
        bus.eng_pc <= bus.req_pc[gnt*PC_W +: PC_W];
        bus.eng_pos <= bus.req_pos[gnt*POS_W +: POS_W];
        cnt <= '0;
      end
      if (state == RUN) begin
        cnt <= cnt_inc;
        if (bus.eng_done) begin
          bus.rsp_matched <= bus.eng_matched;
          bus.rsp_aborted <= 1'b0;
          bus.rsp_pos <= bus.eng_matched ? bus.eng_end_pos : bus.eng_pos;
          bus.last_cycles <= cnt_inc;
        end
      end
      // the halted engine's own result is meaningless, so only its done pulse is used
      if (state == ABORT && bus.eng_done) begin
        bus.rsp_matched <= 1'b0;
        bus.rsp_aborted <= 1'b1;
        bus.rsp_pos <= bus.eng_pos;
        bus.last_cycles <= CNT_W'(MAX_CYCLES);
      end
      if (rsp_hs) rr_ptr <= owner == PTR_W'(NREQ - 1) ? '0 : owner + 1'b1;
    end
endmodule
